// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC sequencer, redirect arbiter and stale-response filter.
// Optional macro FETCH_REDIRECT_PERF_EN adds 32-bit redirect/drop event counters.
`default_nettype none

module fetch_redirect_ctrl #(
  parameter int              ALEN            = 32,
  parameter logic [ALEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [ALEN-1:0] trap_target,
  input  logic            mispredict_valid,
  input  logic [ALEN-1:0] mispredict_target,
  input  logic            predict_valid,
  input  logic [ALEN-1:0] predict_target,
  input  logic            stall,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [ALEN-1:0] req_addr,
  input  logic            resp_valid,
  output logic            out_valid,
  output logic [ALEN-1:0] out_addr,
  output logic            flush
`ifdef FETCH_REDIRECT_PERF_EN
  ,
  output logic [31:0]     perf_trap_cnt,
  output logic [31:0]     perf_mispredict_cnt,
  output logic [31:0]     perf_predict_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam logic [1:0] c_MAX_OUT = 2'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ALEN-1:0] r_pc;
  logic [1:0]      r_out;
  logic [1:0]      r_drop;
  logic            r_flush;
  logic [1:0]      r_wr_ptr;
  logic [1:0]      r_rd_ptr;
  logic [ALEN-1:0] r_fifo [0:3];

  logic            w_active;
  logic            w_resp;
  logic            w_resp_drop;
  logic            w_resp_keep;
  logic            w_trap;
  logic            w_misp;
  logic            w_pred;
  logic            w_redir;
  logic [ALEN-1:0] w_target;
  logic [ALEN-1:0] w_pc_al;
  logic            w_req_valid;
  logic            w_hs;
  logic [1:0]      w_out_nxt;
  logic [1:0]      w_drop_nxt;

  always_comb begin
    w_active    = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    // A response with nothing in flight is a protocol error and is ignored.
    w_resp      = resp_valid && (r_out != 2'd0);
    w_resp_drop = w_resp && (r_drop != 2'd0);
    w_resp_keep = w_resp && (r_drop == 2'd0);

    w_trap   = trap_valid && w_active;
    w_misp   = mispredict_valid && w_active && !trap_valid;
    // A prediction only refers to a response actually delivered this cycle.
    w_pred   = predict_valid && w_resp_keep && (r_state == ST_RUN) &&
               !trap_valid && !mispredict_valid;
    w_redir  = w_trap || w_misp || w_pred;

    w_target = predict_target;
    if (w_trap) begin
      w_target = trap_target;
    end else if (w_misp) begin
      w_target = mispredict_target;
    end

    w_pc_al     = {r_pc[ALEN-1:2], 2'b00};
    w_req_valid = (r_state == ST_RUN) && !stall && (r_out < c_MAX_OUT) && !w_redir;
    w_hs        = w_req_valid && req_ready;

    w_out_nxt  = r_out + (w_hs ? 2'd1 : 2'd0) - (w_resp ? 2'd1 : 2'd0);
    // Everything still in flight after this cycle belongs to the old path.
    w_drop_nxt = w_redir ? w_out_nxt : (r_drop - (w_resp_drop ? 2'd1 : 2'd0));

    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_redir) w_state_nxt = (w_drop_nxt != 2'd0) ? ST_FLUSH : ST_RUN;
      ST_FLUSH: w_state_nxt = (w_drop_nxt != 2'd0) ? ST_FLUSH : ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_out    <= 2'd0;
      r_drop   <= 2'd0;
      r_flush  <= 1'b0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_drop  <= w_drop_nxt;
      r_flush <= w_redir;
      if (w_redir) begin
        r_pc <= w_target;
      end else if (w_hs) begin
        r_pc <= r_pc + ALEN'(4);
      end
      if (w_hs) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_resp) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_fifo[r_wr_ptr] <= w_pc_al;
    end
  end

  assign req_valid = w_req_valid;
  assign req_addr  = w_req_valid ? w_pc_al : '0;
  assign out_valid = w_resp_keep;
  assign out_addr  = w_resp_keep ? r_fifo[r_rd_ptr] : '0;
  assign flush     = r_flush;

`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] r_perf_trap;
  logic [31:0] r_perf_misp;
  logic [31:0] r_perf_pred;
  logic [31:0] r_perf_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_trap <= 32'd0;
      r_perf_misp <= 32'd0;
      r_perf_pred <= 32'd0;
      r_perf_drop <= 32'd0;
    end else begin
      if (w_trap)      r_perf_trap <= r_perf_trap + 32'd1;
      if (w_misp)      r_perf_misp <= r_perf_misp + 32'd1;
      if (w_pred)      r_perf_pred <= r_perf_pred + 32'd1;
      if (w_resp_drop) r_perf_drop <= r_perf_drop + 32'd1;
    end
  end

  assign perf_trap_cnt       = r_perf_trap;
  assign perf_mispredict_cnt = r_perf_misp;
  assign perf_predict_cnt    = r_perf_pred;
  assign perf_drop_cnt       = r_perf_drop;
`endif

  a_resp_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(resp_valid && (r_out == 2'd0)));
  a_out_cap: assert property (@(posedge clk) disable iff (!rst)
    (r_out <= c_MAX_OUT));

endmodule

`default_nettype wire
